// File: rtl/serial_frame_rx_if.sv
// Word handshake between the serial frame receiver and its consumer.
// The receiver drives data/valid and the consumer drives ready.
interface serial_frame_rx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/serial_frame_rx.sv
// Frames a one-bit-per-clock serial stream (start, LSB-first data, optional
// even parity, stop) and hands good words out on a valid/ready interface.
module serial_frame_rx #(
   parameter int WIDTH  = 8,
   parameter int PARITY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in,
   input  logic                    clr_ovr,
   serial_frame_rx_if.master       bus,
   output logic                    parity_err,
   output logic                    frame_err,
   output logic                    overrun
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DATA      = 3'd1,
      PAR       = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] shift_reg;
   logic             par_bad_reg;
   logic [WIDTH-1:0] data_reg;
   logic             valid_reg;
   logic             parity_err_reg;
   logic             frame_err_reg;
   logic             overrun_reg;

   logic             shift_en;
   logic             cnt_clr;
   logic             par_sample;
   logic             good_frame;
   logic             perr_set;
   logic             ferr_set;
   logic             last_bit;

   assign last_bit = (cnt_reg == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (!in) state_next = DATA;
         end
         DATA: begin
            if (last_bit) state_next = (PARITY != 0) ? PAR : STOP;
         end
         PAR: begin
            state_next = STOP;
         end
         STOP: begin
            state_next = in ? IDLE : WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (in) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Stop-bit decode: a low stop bit masks any parity verdict.
   always_comb begin
      shift_en   = 1'b0;
      cnt_clr    = 1'b0;
      par_sample = 1'b0;
      good_frame = 1'b0;
      perr_set   = 1'b0;
      ferr_set   = 1'b0;
      case (state_reg)
         IDLE:  cnt_clr    = 1'b1;
         DATA:  shift_en   = 1'b1;
         PAR:   par_sample = 1'b1;
         STOP: begin
            good_frame = in && !par_bad_reg;
            perr_set   = in && par_bad_reg;
            ferr_set   = !in;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg        <= '0;
         shift_reg      <= '0;
         par_bad_reg    <= 1'b0;
         data_reg       <= '0;
         valid_reg      <= 1'b0;
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         if (cnt_clr) begin
            cnt_reg     <= '0;
            par_bad_reg <= 1'b0;
         end
         if (shift_en) begin
            shift_reg <= {in, shift_reg[WIDTH-1:1]};
            cnt_reg   <= cnt_reg + CW'(1);
         end
         // Even parity: data ones plus the parity bit must be even.
         if (par_sample) begin
            par_bad_reg <= (^shift_reg) ^ in;
         end

         parity_err_reg <= perr_set;
         frame_err_reg  <= ferr_set;

         if (good_frame && (!valid_reg || bus.ready)) begin
            data_reg  <= shift_reg;
            valid_reg <= 1'b1;
         end else if (valid_reg && bus.ready) begin
            valid_reg <= 1'b0;
         end

         if (good_frame && valid_reg && !bus.ready) begin
            overrun_reg <= 1'b1;
         end else if (clr_ovr) begin
            overrun_reg <= 1'b0;
         end
      end
   end

   assign bus.data   = data_reg;
   assign bus.valid  = valid_reg;
   assign parity_err = parity_err_reg;
   assign frame_err  = frame_err_reg;
   assign overrun    = overrun_reg;

endmodule
